// File: rtl/btn_param_ctrl.sv
// btn_param_ctrl: four saturating parameter registers adjusted by UP/DOWN
// keys. A key press steps the selected register once; holding the key starts
// auto-repeat after HOLD_DLY cycles, then repeats every RPT_PER cycles.
// SELECT rotates through the four registers and cancels any hold/repeat.
module btn_param_ctrl #(
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_VAL  = 255,
    parameter int unsigned RST_VAL  = 128,
    parameter int unsigned STEP     = 1,
    parameter int unsigned HOLD_DLY = 25_000_000,
    parameter int unsigned RPT_PER  = 5_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         up_level,
    input  logic         up_tick,
    input  logic         dn_level,
    input  logic         dn_tick,
    input  logic         sel_tick,
    output logic [1:0]   cur_idx,
    output logic [W-1:0] p0,
    output logic [W-1:0] p1,
    output logic [W-1:0] p2,
    output logic [W-1:0] p3,
    output logic         upd_tick
);

    // Counter must hold the larger of the two reload values (value - 1).
    localparam int unsigned CNT_MAX = (HOLD_DLY > RPT_PER) ? HOLD_DLY : RPT_PER;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_DLY - 1);
    localparam logic [CW-1:0] RPT_LOAD  = CW'(RPT_PER - 1);
    localparam logic [W:0]    STEP_X    = (W+1)'(STEP);
    localparam logic [W:0]    MAX_X     = (W+1)'(MAX_VAL);
    localparam logic [W-1:0]  RST_P     = W'(RST_VAL);

    typedef enum logic [2:0] {
        IDLE,
        HOLD_UP,
        RPT_UP,
        HOLD_DN,
        RPT_DN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    idx_nxt;
    logic          step_up;
    logic          step_dn;

    logic [W-1:0]  pr [4];
    logic [W-1:0]  cur_val;
    logic [W-1:0]  new_val;
    logic [W:0]    up_sum;
    logic          changed;

    // State register, hold/repeat counter and selection index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cur_idx <= idx_nxt;
        end
    end

    // Next-state logic: decides when a step is requested and reloads the counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = cur_idx;
        step_up   = 1'b0;
        step_dn   = 1'b0;

        if (sel_tick) begin
            // Selection wins over everything, including an active repeat.
            idx_nxt   = cur_idx + 2'd1;
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (up_tick && !dn_tick) begin
                        step_up   = 1'b1;
                        state_nxt = HOLD_UP;
                        cnt_nxt   = HOLD_LOAD;
                    end else if (dn_tick && !up_tick) begin
                        step_dn   = 1'b1;
                        state_nxt = HOLD_DN;
                        cnt_nxt   = HOLD_LOAD;
                    end
                end
                HOLD_UP: begin
                    if (!up_level) begin
                        state_nxt = IDLE;
                    end else if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        step_up   = 1'b1;
                        state_nxt = RPT_UP;
                        cnt_nxt   = RPT_LOAD;
                    end
                end
                RPT_UP: begin
                    if (!up_level) begin
                        state_nxt = IDLE;
                    end else if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        step_up = 1'b1;
                        cnt_nxt = RPT_LOAD;
                    end
                end
                HOLD_DN: begin
                    if (!dn_level) begin
                        state_nxt = IDLE;
                    end else if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        step_dn   = 1'b1;
                        state_nxt = RPT_DN;
                        cnt_nxt   = RPT_LOAD;
                    end
                end
                RPT_DN: begin
                    if (!dn_level) begin
                        state_nxt = IDLE;
                    end else if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        step_dn = 1'b1;
                        cnt_nxt = RPT_LOAD;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Saturating step of the selected register; flags whether it actually moved.
    always_comb begin
        cur_val = pr[cur_idx];
        up_sum  = {1'b0, cur_val} + STEP_X;
        new_val = cur_val;
        if (step_up) begin
            new_val = (up_sum > MAX_X) ? MAX_X[W-1:0] : up_sum[W-1:0];
        end else if (step_dn) begin
            new_val = ({1'b0, cur_val} < STEP_X) ? '0 : (cur_val - STEP_X[W-1:0]);
        end
        changed = (new_val != cur_val);
    end

    // Parameter storage and update pulse; only the selected register is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                pr[i] <= RST_P;
            end
            upd_tick <= 1'b0;
        end else begin
            if (changed) begin
                pr[cur_idx] <= new_val;
            end
            upd_tick <= changed;
        end
    end

    assign p0 = pr[0];
    assign p1 = pr[1];
    assign p2 = pr[2];
    assign p3 = pr[3];

endmodule
